// File: rtl/seq_det_pkg.sv
// Shared helpers for the serial pattern detector: prefix-function math used to
// build the constant next-state table at elaboration.
package seq_det_pkg;

  localparam int MAX_PAT_W = 16;

  // Bit i of the pattern in arrival order (i = 0 is the first bit received).
  function automatic logic pat_bit(input logic [MAX_PAT_W-1:0] pattern,
                                   input int pat_w, input int i);
    return pattern[pat_w-1-i];
  endfunction

  // Longest pattern prefix that is a suffix of (prefix[len] ++ b).
  function automatic int next_len(input logic [MAX_PAT_W-1:0] pattern,
                                  input int pat_w, input int len, input logic b);
    int   best;
    int   j;
    logic ok;
    logic sb;
    best = 0;
    for (int k = 1; k <= MAX_PAT_W; k++) begin
      if (k <= len + 1 && k <= pat_w) begin
        ok = 1'b1;
        for (int i = 0; i < MAX_PAT_W; i++) begin
          if (i < k) begin
            j  = len + 1 - k + i;
            sb = (j == len) ? b : pat_bit(pattern, pat_w, j);
            if (sb != pat_bit(pattern, pat_w, i)) ok = 1'b0;
          end
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  // Longest proper prefix of prefix[len] that is also its suffix.
  function automatic int fail_len(input logic [MAX_PAT_W-1:0] pattern,
                                  input int pat_w, input int len);
    int   best;
    logic ok;
    best = 0;
    for (int k = 1; k < MAX_PAT_W; k++) begin
      if (k < len) begin
        ok = 1'b1;
        for (int i = 0; i < MAX_PAT_W; i++) begin
          if (i < k && pat_bit(pattern, pat_w, len - k + i) != pat_bit(pattern, pat_w, i))
            ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_detector_p_sat_counter.sv
// Saturating event counter with synchronous clear; sat flags the all-ones value.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic [CNT_W-1:0] r_count;
  logic             w_sat;

  assign w_sat = &r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               r_count <= '0;
    else if (clr)             r_count <= '0;
    else if (inc && !w_sat)   r_count <= r_count + 1'b1;
  end

  assign count = r_count;
  assign sat   = w_sat;

endmodule

// File: rtl/seq_detector_p.sv
// Parametrised serial pattern detector: KMP-style prefix-length FSM with a
// Mealy match pulse, its registered copy and a saturating match counter.
module seq_detector_p
  import seq_det_pkg::*;
#(
  parameter  int               PAT_W   = 4,
  parameter  logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter  int               CNT_W   = 8,
  localparam int               ST_W    = $clog2(PAT_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             x_vld,
  input  logic             ovl,
  input  logic             clr,
  output logic [ST_W-1:0]  state,
  output logic             match,
  output logic             match_q,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  typedef logic [ST_W-1:0] st_t;

  st_t  r_state;
  logic r_match_q;
  st_t  w_tbl [PAT_W][2];
  st_t  w_nst;
  logic w_hit;
  logic w_match;

  // Constant transition table; the full-match entry holds the overlap restart.
  always_comb begin
    for (int s = 0; s < PAT_W; s++) begin
      for (int b = 0; b < 2; b++) begin
        w_tbl[s][b] = st_t'(next_len(MAX_PAT_W'(PATTERN), PAT_W, s, 1'(b)));
      end
    end
    w_tbl[PAT_W-1][PATTERN[0]] = st_t'(fail_len(MAX_PAT_W'(PATTERN), PAT_W, PAT_W));
  end

  assign w_hit   = (int'(r_state) == PAT_W - 1) && x_vld && (x == PATTERN[0]);
  assign w_match = rst_n && !clr && w_hit;

  always_comb begin
    w_nst = r_state;
    if (clr) begin
      w_nst = '0;
    end else if (x_vld) begin
      if (int'(r_state) >= PAT_W)  w_nst = '0;
      else if (w_hit && !ovl)      w_nst = '0;
      else                         w_nst = w_tbl[r_state][x];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= '0;
      r_match_q <= 1'b0;
    end else begin
      r_state   <= w_nst;
      r_match_q <= w_match;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (w_match),
    .count (count),
    .sat   (sat)
  );

  assign state   = r_state;
  assign match   = w_match;
  assign match_q = r_match_q;

endmodule

// File: tb/tb_seq_detector_p.sv
// Directed bench for seq_detector_p: default 1011 detector, a 2-bit-counter
// copy for saturation and a 111 detector for the all-equal-bits case.
module tb_seq_detector_p;

  logic       clk = 1'b0;
  logic       rst_n, x, x_vld, ovl, clr;
  logic [1:0] state, state2, state3;
  logic       match, match_q, sat;
  logic       match2, match_q2, sat2;
  logic       match3, match_q3, sat3;
  logic [7:0] count, count3;
  logic [1:0] count2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_detector_p u_dut (
    .clk(clk), .rst_n(rst_n), .x(x), .x_vld(x_vld), .ovl(ovl), .clr(clr),
    .state(state), .match(match), .match_q(match_q), .count(count), .sat(sat)
  );

  seq_detector_p #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .x(x), .x_vld(x_vld), .ovl(ovl), .clr(clr),
    .state(state2), .match(match2), .match_q(match_q2), .count(count2), .sat(sat2)
  );

  seq_detector_p #(.PAT_W(3), .PATTERN(3'b111), .CNT_W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .x(x), .x_vld(x_vld), .ovl(ovl), .clr(clr),
    .state(state3), .match(match3), .match_q(match_q3), .count(count3), .sat(sat3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic bx, input logic bv);
    x     = bx;
    x_vld = bv;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    x_vld = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic send(input logic bx, input logic exp_m, input string tag);
    set_in(bx, 1'b1);
    chk(tag, 32'(match), 32'(exp_m));
    tick();
  endtask

  task automatic do_clr();
    clr   = 1'b1;
    x_vld = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; x = 1'b0; x_vld = 1'b0; ovl = 1'b1; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_match_q", 32'(match_q), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    rst_n = 1'b1;

    // Async reset mid-pattern, then a clean 1011
    send(1'b1, 1'b0, "t1_b1");
    send(1'b0, 1'b0, "t1_b2");
    chk("t1_state_pre", 32'(state), 32'd2);
    rst_n = 1'b0;
    #2;
    chk("t1_async_state", 32'(state), 32'd0);
    chk("t1_async_count", 32'(count), 32'd0);
    chk("t1_async_match_q", 32'(match_q), 32'd0);
    chk("t1_async_match", 32'(match), 32'd0);
    rst_n = 1'b1;
    send(1'b1, 1'b0, "t1_c1");
    send(1'b0, 1'b0, "t1_c2");
    send(1'b1, 1'b0, "t1_c3");
    send(1'b1, 1'b1, "t1_c4");
    chk("t1_count", 32'(count), 32'd1);
    chk("t1_match_q", 32'(match_q), 32'd1);
    chk("t1_state", 32'(state), 32'd1);

    // Overlap: 1011011
    do_clr();
    chk("clr_state", 32'(state), 32'd0);
    chk("clr_count", 32'(count), 32'd0);
    ovl = 1'b1;
    send(1'b1, 1'b0, "t2_b1");
    send(1'b0, 1'b0, "t2_b2");
    send(1'b1, 1'b0, "t2_b3");
    send(1'b1, 1'b1, "t2_b4");
    chk("t2_match_q4", 32'(match_q), 32'd1);
    chk("t2_state4", 32'(state), 32'd1);
    send(1'b0, 1'b0, "t2_b5");
    chk("t2_match_q5", 32'(match_q), 32'd0);
    chk("t2_state5", 32'(state), 32'd2);
    send(1'b1, 1'b0, "t2_b6");
    send(1'b1, 1'b1, "t2_b7");
    chk("t2_state7", 32'(state), 32'd1);
    chk("t2_count", 32'(count), 32'd2);
    chk("t2_match_q7", 32'(match_q), 32'd1);

    // Non-overlap: same stream, one match
    do_clr();
    ovl = 1'b0;
    send(1'b1, 1'b0, "t3_b1");
    send(1'b0, 1'b0, "t3_b2");
    send(1'b1, 1'b0, "t3_b3");
    send(1'b1, 1'b1, "t3_b4");
    chk("t3_state4", 32'(state), 32'd0);
    send(1'b0, 1'b0, "t3_b5");
    send(1'b1, 1'b0, "t3_b6");
    send(1'b1, 1'b0, "t3_b7");
    chk("t3_state7", 32'(state), 32'd1);
    chk("t3_count", 32'(count), 32'd1);

    // Invalid-bit gap holds state
    do_clr();
    ovl = 1'b1;
    send(1'b1, 1'b0, "t4_b1");
    send(1'b0, 1'b0, "t4_b2");
    for (int i = 0; i < 3; i++) begin
      set_in(i[0], 1'b0);
      chk("t4_gap_match", 32'(match), 32'd0);
      tick();
      chk("t4_gap_state", 32'(state), 32'd2);
    end
    send(1'b1, 1'b0, "t4_b3");
    chk("t4_state3", 32'(state), 32'd3);
    send(1'b1, 1'b1, "t4_b4");
    chk("t4_count", 32'(count), 32'd1);

    // clr collides with the final bit
    do_clr();
    send(1'b1, 1'b0, "t5_b1");
    send(1'b0, 1'b0, "t5_b2");
    send(1'b1, 1'b0, "t5_b3");
    clr = 1'b1;
    set_in(1'b1, 1'b1);
    chk("t5_clr_match", 32'(match), 32'd0);
    tick();
    chk("t5_clr_state", 32'(state), 32'd0);
    chk("t5_clr_count", 32'(count), 32'd0);
    chk("t5_clr_match_q", 32'(match_q), 32'd0);
    send(1'b1, 1'b0, "t5_c1");
    send(1'b0, 1'b0, "t5_c2");
    send(1'b1, 1'b0, "t5_c3");
    send(1'b1, 1'b1, "t5_c4");
    chk("t5_count", 32'(count), 32'd1);

    // Saturation on the 2-bit counter copy
    do_clr();
    ovl = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send(1'b1, 1'b0, "t6_b1");
      send(1'b0, 1'b0, "t6_b2");
      send(1'b1, 1'b0, "t6_b3");
      set_in(1'b1, 1'b1);
      chk("t6_match2", 32'(match2), 32'd1);
      tick();
      chk("t6_count2", 32'(count2), (k < 2) ? 32'(k + 1) : 32'd3);
      chk("t6_sat2", 32'(sat2), (k >= 2) ? 32'd1 : 32'd0);
    end
    chk("t6_count_wide", 32'(count), 32'd5);
    chk("t6_sat_wide", 32'(sat), 32'd0);

    // All-equal pattern 111 with overlap
    do_clr();
    ovl = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_in(1'b1, 1'b1);
      chk("t7_match3", 32'(match3), (k >= 2) ? 32'd1 : 32'd0);
      tick();
      chk("t7_state3", 32'(state3), (k == 0) ? 32'd1 : 32'd2);
    end
    chk("t7_count3", 32'(count3), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
